// File: rtl/emergency_interlock.sv
// Emergency interlock: turns SOS / overweight flags into brake, door,
// motion-grant and buzzer commands with a safe-stop and recovery sequence.
module emergency_interlock #(
  parameter int unsigned BEEP_HALF   = 12_500_000,
  parameter int unsigned STOP_SETTLE = 50_000_000,
  parameter int unsigned CLEAR_HOLD  = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sos_mode,
  input  logic       weight_limit_exceeded,
  input  logic       car_moving,
  input  logic       door_closed,
  input  logic       move_request,
  output logic       move_grant,
  output logic       brake_engage,
  output logic       door_lock_release,
  output logic       buzzer,
  output logic [2:0] state_code
);

  localparam int BW = $clog2(BEEP_HALF + 1);
  localparam int SW = $clog2(STOP_SETTLE + 1);
  localparam int CW = $clog2(CLEAR_HOLD + 1);

  localparam logic [BW-1:0] BEEP_LAST   = BW'(BEEP_HALF - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(STOP_SETTLE - 1);
  localparam logic [CW-1:0] CLEAR_LAST  = CW'(CLEAR_HOLD - 1);

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    OVERWEIGHT = 3'd1,
    SOS_STOP   = 3'd2,
    SOS_HALT   = 3'd3,
    RECOVER    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] clear_q, clear_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          buzzer_q, buzzer_d;
  logic          grant_q, grant_d;
  logic          beep_state_q, beep_state_d;

  // Counters default to zero, so every state change clears them.
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    clear_d  = '0;
    unique case (state_q)
      NORMAL: begin
        if (sos_mode)
          state_d = SOS_STOP;
        else if (weight_limit_exceeded && !car_moving)
          state_d = OVERWEIGHT;
      end
      OVERWEIGHT: begin
        if (sos_mode)
          state_d = SOS_STOP;
        else if (!weight_limit_exceeded)
          state_d = NORMAL;
      end
      SOS_STOP: begin
        if (car_moving)
          settle_d = '0;
        else if (settle_q == SETTLE_LAST)
          state_d = SOS_HALT;
        else
          settle_d = settle_q + SW'(1);
      end
      SOS_HALT: begin
        if (!sos_mode)
          state_d = RECOVER;
      end
      RECOVER: begin
        if (sos_mode)
          state_d = SOS_HALT;
        else if (clear_q == CLEAR_LAST)
          state_d = weight_limit_exceeded ? OVERWEIGHT : NORMAL;
        else
          clear_d = clear_q + CW'(1);
      end
      default: state_d = NORMAL;
    endcase
  end

  assign beep_state_q = (state_q == OVERWEIGHT) || (state_q == SOS_HALT);
  assign beep_state_d = (state_d == OVERWEIGHT) || (state_d == SOS_HALT);

  // Any entry into a beeping state restarts the tone phase high.
  always_comb begin
    beep_d   = '0;
    buzzer_d = 1'b0;
    if (state_d != state_q) begin
      buzzer_d = beep_state_d;
    end else if (beep_state_q) begin
      if (beep_q == BEEP_LAST) begin
        buzzer_d = ~buzzer_q;
      end else begin
        beep_d   = beep_q + BW'(1);
        buzzer_d = buzzer_q;
      end
    end
  end

  assign grant_d = (state_d == NORMAL) && move_request && door_closed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= NORMAL;
      settle_q <= '0;
      clear_q  <= '0;
      beep_q   <= '0;
      buzzer_q <= 1'b0;
      grant_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      clear_q  <= clear_d;
      beep_q   <= beep_d;
      buzzer_q <= buzzer_d;
      grant_q  <= grant_d;
    end
  end

  assign brake_engage      = (state_q == SOS_STOP) ||
                             (state_q == SOS_HALT) ||
                             (state_q == RECOVER);
  assign door_lock_release = (state_q == OVERWEIGHT) ||
                             (state_q == SOS_HALT) ||
                             (state_q == RECOVER);
  assign move_grant        = grant_q;
  assign buzzer            = buzzer_q;
  assign state_code        = state_q;

endmodule

// File: tb/tb_emergency_interlock.sv
// Directed bench for emergency_interlock with short timing parameters.
module tb_emergency_interlock;

  logic       clk = 1'b0;
  logic       reset;
  logic       sos_mode;
  logic       weight_limit_exceeded;
  logic       car_moving;
  logic       door_closed;
  logic       move_request;
  logic       move_grant;
  logic       brake_engage;
  logic       door_lock_release;
  logic       buzzer;
  logic [2:0] state_code;

  int n_cmp = 0;
  int n_err = 0;

  emergency_interlock #(
    .BEEP_HALF  (4),
    .STOP_SETTLE(8),
    .CLEAR_HOLD (6)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .sos_mode             (sos_mode),
    .weight_limit_exceeded(weight_limit_exceeded),
    .car_moving           (car_moving),
    .door_closed          (door_closed),
    .move_request         (move_request),
    .move_grant           (move_grant),
    .brake_engage         (brake_engage),
    .door_lock_release    (door_lock_release),
    .buzzer               (buzzer),
    .state_code           (state_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [8:0] bz_pat;

  initial begin
    bz_pat = 9'b1_0000_1111;
    reset = 1'b1;
    sos_mode = 1'b1;
    weight_limit_exceeded = 1'b0;
    car_moving = 1'b0;
    door_closed = 1'b0;
    move_request = 1'b0;

    // reset held with sos asserted
    ticks(2);
    check("rst_state", 32'(state_code), 32'd0);
    check("rst_brake", 32'(brake_engage), 32'd0);
    check("rst_grant", 32'(move_grant), 32'd0);
    check("rst_buzz", 32'(buzzer), 32'd0);
    check("rst_door", 32'(door_lock_release), 32'd0);
    reset = 1'b0;
    tick();
    check("rel_state", 32'(state_code), 32'd2);
    check("rel_brake", 32'(brake_engage), 32'd1);
    check("rel_grant", 32'(move_grant), 32'd0);

    // grant latency and drop on sos
    reset = 1'b1;
    #1;
    reset = 1'b0;
    sos_mode = 1'b0;
    door_closed = 1'b1;
    move_request = 1'b1;
    tick();
    check("norm_state", 32'(state_code), 32'd0);
    check("grant_on", 32'(move_grant), 32'd1);
    sos_mode = 1'b1;
    tick();
    check("sos_state", 32'(state_code), 32'd2);
    check("sos_grant", 32'(move_grant), 32'd0);
    check("sos_brake", 32'(brake_engage), 32'd1);
    check("sos_door", 32'(door_lock_release), 32'd0);

    // settle counter restarts on any motion
    car_moving = 1'b1;
    ticks(5);
    car_moving = 1'b0;
    ticks(3);
    car_moving = 1'b1;
    tick();
    check("settle_mv", 32'(state_code), 32'd2);
    car_moving = 1'b0;
    ticks(7);
    check("settle_7", 32'(state_code), 32'd2);
    tick();
    check("halt_state", 32'(state_code), 32'd3);
    check("halt_door", 32'(door_lock_release), 32'd1);
    check("halt_brake", 32'(brake_engage), 32'd1);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("beep%0d", i), 32'(buzzer), 32'(bz_pat[i]));
      if (i < 8) tick();
    end

    // recovery interrupted by a one-cycle sos pulse
    sos_mode = 1'b0;
    tick();
    check("rec_state", 32'(state_code), 32'd4);
    check("rec_buzz", 32'(buzzer), 32'd0);
    ticks(3);
    sos_mode = 1'b1;
    tick();
    check("pulse_halt", 32'(state_code), 32'd3);
    check("pulse_buzz", 32'(buzzer), 32'd1);
    sos_mode = 1'b0;
    tick();
    check("rec2_state", 32'(state_code), 32'd4);
    ticks(5);
    check("rec2_hold", 32'(state_code), 32'd4);
    check("rec2_brake", 32'(brake_engage), 32'd1);
    check("rec2_door", 32'(door_lock_release), 32'd1);
    tick();
    check("back_norm", 32'(state_code), 32'd0);
    check("back_brake", 32'(brake_engage), 32'd0);
    check("back_grant", 32'(move_grant), 32'd1);

    // recovery ends into overweight
    sos_mode = 1'b1;
    tick();
    check("sos2_state", 32'(state_code), 32'd2);
    ticks(8);
    check("halt2", 32'(state_code), 32'd3);
    sos_mode = 1'b0;
    weight_limit_exceeded = 1'b1;
    tick();
    check("rec3_state", 32'(state_code), 32'd4);
    ticks(6);
    check("ow_state", 32'(state_code), 32'd1);
    check("ow_door", 32'(door_lock_release), 32'd1);
    check("ow_brake", 32'(brake_engage), 32'd0);
    check("ow_buzz_on", 32'(buzzer), 32'd1);
    check("ow_grant", 32'(move_grant), 32'd0);
    ticks(4);
    check("ow_buzz_off", 32'(buzzer), 32'd0);
    weight_limit_exceeded = 1'b0;
    tick();
    check("ow_exit", 32'(state_code), 32'd0);
    check("ow_exit_door", 32'(door_lock_release), 32'd0);

    // overweight ignored while moving
    car_moving = 1'b1;
    weight_limit_exceeded = 1'b1;
    ticks(2);
    check("mv_ignore", 32'(state_code), 32'd0);
    check("mv_grant", 32'(move_grant), 32'd1);
    car_moving = 1'b0;
    tick();
    check("ow2_state", 32'(state_code), 32'd1);
    check("ow2_grant", 32'(move_grant), 32'd0);

    // asynchronous abort mid-state
    #3;
    reset = 1'b1;
    #1;
    check("arst_state", 32'(state_code), 32'd0);
    check("arst_door", 32'(door_lock_release), 32'd0);
    check("arst_buzz", 32'(buzzer), 32'd0);
    check("arst_brake", 32'(brake_engage), 32'd0);
    check("arst_grant", 32'(move_grant), 32'd0);
    ticks(1);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/emergency_interlock.md
Name: emergency_interlock

Overview:
- Consumes the emergency flags `sos_mode` and `weight_limit_exceeded` produced by the emergency module.
- Turns them into actuator commands: motion grant, brake, door-lock release and a beeping buzzer.
- Sits between the emergency module and the motor/door controllers.
- Sequences a safe stop, a hold period and a debounced recovery back to normal service.

Parameters:
BEEP_HALF, 12_500_000, buzzer half-period in clk cycles (>=1)
STOP_SETTLE, 50_000_000, consecutive cycles with car_moving=0 needed to confirm standstill (>=1)
CLEAR_HOLD, 100_000_000, consecutive cycles with sos_mode=0 needed before leaving recovery (>=1)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
sos_mode  input  1  SOS active flag from the emergency module
weight_limit_exceeded  input  1  overweight flag from the emergency module
car_moving  input  1  motor status: 1 while the car is in motion
door_closed  input  1  door fully closed
move_request  input  1  dispatcher requests motion
move_grant  output  1  motion permitted (registered)
brake_engage  output  1  force mechanical brake
door_lock_release  output  1  allow doors to open regardless of floor logic
buzzer  output  1  audible alarm drive (registered)
state_code  output  3  current FSM state encoding

Behaviour:
- Reset (async, active-high): state=NORMAL(0); move_grant, buzzer, brake_engage, door_lock_release = 0; all counters = 0. Asserting reset mid-sequence aborts immediately. The first edge after release evaluates inputs normally, so a held sos_mode enters SOS_STOP on that edge.
- States / state_code: NORMAL=0, OVERWEIGHT=1, SOS_STOP=2, SOS_HALT=3, RECOVER=4. Codes 5-7 are illegal and recover to NORMAL on the next edge.
- Priority in every state: sos_mode wins over weight. Exceptions: SOS_HALT and RECOVER go to SOS_HALT on sos_mode, because standstill is already confirmed.
- NORMAL:
  - sos_mode=1 -> SOS_STOP.
  - Otherwise weight_limit_exceeded=1 and car_moving=0 -> OVERWEIGHT.
  - Overweight while moving is ignored; the car finishes its trip.
- OVERWEIGHT:
  - door_lock_release=1, brake_engage=0, buzzer beeps.
  - weight_limit_exceeded=0 -> NORMAL on the next edge.
- SOS_STOP:
  - brake_engage=1, door_lock_release=0.
  - settle_cnt increments on each cycle with car_moving=0 and clears to 0 on any cycle with car_moving=1.
  - Transition -> SOS_HALT on the edge where settle_cnt reaches STOP_SETTLE-1 with car_moving=0, i.e. after STOP_SETTLE consecutive still cycles.
  - sos_mode dropping here does NOT abort the stop.
- SOS_HALT:
  - brake_engage=1, door_lock_release=1, buzzer beeps.
  - sos_mode=0 -> RECOVER.
- RECOVER:
  - brake_engage=1, door_lock_release=1, buzzer=0.
  - clear_cnt increments each cycle with sos_mode=0; sos_mode=1 -> SOS_HALT with clear_cnt cleared.
  - At the CLEAR_HOLD-th consecutive clear cycle: -> OVERWEIGHT if weight_limit_exceeded=1, else -> NORMAL.
- Output decode: brake_engage and door_lock_release are Moore decodes of the state register.
- move_grant register: each edge loads (next_state==NORMAL) & move_request & door_closed. It therefore drops on the same edge the FSM leaves NORMAL, and has one-cycle latency from move_request.
- Beep generator (active in OVERWEIGHT and SOS_HALT):
  - On the entry edge, buzzer<=1 and beep_cnt<=0.
  - Each cycle beep_cnt increments; at BEEP_HALF-1 it wraps to 0 and buzzer toggles.
  - In any other state, buzzer=0 and beep_cnt=0.
  - Going OVERWEIGHT->SOS_STOP->SOS_HALT restarts the beep phase.
- Counter widths: $clog2(param+1). No counter ever exceeds its terminal value; counters are cleared on every state change.

Test Plan:
All tests use BEEP_HALF=4, STOP_SETTLE=8, CLEAR_HOLD=6.
- Reset with sos_mode=1 held: after release -> state_code 2 on the 1st edge, brake_engage=1, move_grant=0.
- NORMAL, door_closed=1, move_request=1 -> move_grant=1 one cycle later. Then sos_mode=1 -> move_grant=0 and state 2 on the same edge.
- SOS_STOP with car_moving=1 for 5 cycles, 0 for 3, 1 for 1, then 0 -> SOS_HALT exactly 8 still cycles after the last moving cycle. Buzzer then reads 1,1,1,1,0,0,0,0,1.
- SOS_HALT, drop sos_mode for 4 cycles, pulse it 1 cycle, drop again -> back to SOS_HALT on the pulse. Then 6 clear cycles -> NORMAL, brake_engage=0.
- Recovery ends with weight_limit_exceeded=1 -> OVERWEIGHT (code 1), door_lock_release=1, buzzer beeping. Clear weight -> NORMAL next edge.
- weight_limit_exceeded=1 while car_moving=1 -> stays NORMAL. car_moving falls -> OVERWEIGHT next edge. Assert reset mid-state -> all outputs 0 asynchronously.
